// File: rtl/error_campaign_ctrl_pkg.sv
// Shared definitions for the bit-error campaign slice: controller state encoding
// and the stream width used by the lfsr/flipper/checker chain.
package err_pkg;

   localparam int unsigned N_DEFAULT = 5;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PRIME = 2'd1,
      ST_RUN   = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/error_campaign_ctrl_popcount.sv
// Combinational population count of the checker's per-bit mismatch vector.
module popcount #(
   parameter int unsigned N = 5,
   parameter int unsigned W = $clog2(N + 1)
) (
   input  logic [1:N]   bits,
   output logic [W-1:0] count
);

   always_comb begin
      count = '0;
      for (int unsigned i = 1; i <= N; i++) begin
         count = count + W'(bits[i]);
      end
   end

endmodule

// File: rtl/error_campaign_ctrl.sv
// Sequences one bit-error measurement campaign: primes the datapath out of reset,
// samples the checker for window_len cycles into saturating totals, then pulses done.
module error_campaign_ctrl
   import err_pkg::*;
#(
   parameter int unsigned N         = N_DEFAULT,
   parameter int unsigned WIN_W     = 8,
   parameter int unsigned CNT_W     = 16,
   parameter int unsigned PRIME_CYC = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   input  logic [WIN_W-1:0] window_len,
   input  logic             error,
   input  logic [1:N]       bitError,
   output logic             ds_rst,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] err_words,
   output logic [CNT_W-1:0] err_bits
);

   localparam int unsigned PC_W = $clog2(N + 1);
   localparam int unsigned SUM_W = CNT_W + 1;
   localparam logic [WIN_W-1:0] PRIME_LOAD = WIN_W'(PRIME_CYC - 1);

   state_t           state;
   logic [WIN_W-1:0] cnt;
   logic [WIN_W-1:0] win_q;
   logic [PC_W-1:0]  pc;
   logic [SUM_W-1:0] words_sum;
   logic [SUM_W-1:0] bits_sum;
   logic [CNT_W-1:0] words_next;
   logic [CNT_W-1:0] bits_next;

   popcount #(.N(N), .W(PC_W)) u_popcount (
      .bits  (bitError),
      .count (pc)
   );

   // One extra sum bit flags overflow so the totals clamp instead of wrapping.
   always_comb begin
      words_sum  = {1'b0, err_words} + SUM_W'(error);
      bits_sum   = {1'b0, err_bits} + SUM_W'(pc);
      words_next = words_sum[CNT_W] ? '1 : words_sum[CNT_W-1:0];
      bits_next  = bits_sum[CNT_W] ? '1 : bits_sum[CNT_W-1:0];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= ST_IDLE;
         ds_rst    <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
         err_words <= '0;
         err_bits  <= '0;
         cnt       <= '0;
         win_q     <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state     <= ST_PRIME;
                  busy      <= 1'b1;
                  win_q     <= window_len;
                  cnt       <= PRIME_LOAD;
                  err_words <= '0;
                  err_bits  <= '0;
               end
            end
            ST_PRIME: begin
               if (abort) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end else if (cnt == '0) begin
                  if (win_q == '0) begin
                     state <= ST_DONE;
                     done  <= 1'b1;
                  end else begin
                     state  <= ST_RUN;
                     ds_rst <= 1'b0;
                     cnt    <= win_q;
                  end
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ST_RUN: begin
               // The aborting edge is not sampled; totals keep only completed samples.
               if (abort) begin
                  state  <= ST_IDLE;
                  busy   <= 1'b0;
                  ds_rst <= 1'b1;
               end else begin
                  err_words <= words_next;
                  err_bits  <= bits_next;
                  cnt       <= cnt - 1'b1;
                  if (cnt == WIN_W'(1)) begin
                     state  <= ST_DONE;
                     done   <= 1'b1;
                     ds_rst <= 1'b1;
                  end
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
